lpc_target_arbiter: RTL and testbench

//  Shares lpc_periph's single data-provider interface between NUM_TGT register targets (TPM regs, debug port, ...).

---
 rtl/lpc_target_arbiter_pkg.sv | 21 ++
 rtl/lpc_addr_decode.sv | 27 ++
 rtl/lpc_target_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_lpc_target_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_target_arbiter_pkg.sv
// Shared definitions for the LPC target arbiter: FSM state encodings,
// default read data and a window-mask helper.
package lpc_target_arbiter_pkg;

  localparam logic [2:0] LPC_ARB_ST_IDLE    = 3'd0;
  localparam logic [2:0] LPC_ARB_ST_DECODE  = 3'd1;
  localparam logic [2:0] LPC_ARB_ST_WR_WAIT = 3'd2;
  localparam logic [2:0] LPC_ARB_ST_RD_WAIT = 3'd3;
  localparam logic [2:0] LPC_ARB_ST_WR_DONE = 3'd4;
  localparam logic [2:0] LPC_ARB_ST_RD_DONE = 3'd5;

  localparam logic [7:0] LPC_ARB_DFLT_RDATA = 8'hFF;

  // Mask selecting the in-window offset bits of a 16-bit I/O address.
  function automatic logic [15:0] win_mask(input int unsigned bits);
    logic [31:0] m;
    m = (32'd1 << bits) - 32'd1;
    return m[15:0];
  endfunction

endpackage

// File: rtl/lpc_addr_decode.sv
// Combinational window decoder: compares the upper address bits against each
// target base and returns a one-hot hit (lowest index wins on overlap).
module lpc_addr_decode
  import lpc_target_arbiter_pkg::*;
#(
  parameter int unsigned           NUM_TGT  = 2,
  parameter logic [16*NUM_TGT-1:0] TGT_BASE = {16'h0FE0, 16'h0080},
  parameter int unsigned           WIN_BITS = 4
) (
  input  logic [15-WIN_BITS:0] addr_hi,
  output logic [NUM_TGT-1:0]   hit,
  output logic                 hit_any
);

  // Priority compare of the address against every window base.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    for (int unsigned k = 0; k < NUM_TGT; k++) begin
      if (!hit_any && (addr_hi == TGT_BASE[16*k+WIN_BITS +: 16-WIN_BITS])) begin
        hit[k]  = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lpc_target_arbiter.sv
// Shares lpc_periph's single data-provider port between NUM_TGT register
// targets: address window decode, wr/rd handshake sequencing, read data mux,
// and merge of per-target interrupts into one interrupt/irq_num pair.
// Optional feature: define LPC_ARB_TIMEOUT_EN to bound target response time.
module lpc_target_arbiter
  import lpc_target_arbiter_pkg::*;
#(
  parameter int unsigned           NUM_TGT     = 2,
  parameter logic [16*NUM_TGT-1:0] TGT_BASE    = {16'h0FE0, 16'h0080},
  parameter int unsigned           WIN_BITS    = 4,
  parameter int unsigned           TIMEOUT_CYC = 255,
  parameter logic [7:0]            DFLT_RDATA  = LPC_ARB_DFLT_RDATA
) (
  input  logic                   clk_i,
  input  logic                   nrst_i,
  input  logic [15:0]            lpc_addr_i,
  input  logic [7:0]             lpc_wdata_i,
  input  logic                   lpc_data_wr_i,
  output logic                   lpc_wr_done_o,
  input  logic                   lpc_data_req_i,
  output logic                   lpc_data_rd_o,
  output logic [7:0]             lpc_rdata_o,
  output logic [3:0]             irq_num_o,
  output logic                   interrupt_o,
  output logic [15:0]            tgt_addr_o,
  output logic [7:0]             tgt_wdata_o,
  output logic [NUM_TGT-1:0]     tgt_wr_o,
  input  logic [NUM_TGT-1:0]     tgt_wr_done_i,
  output logic [NUM_TGT-1:0]     tgt_rd_o,
  input  logic [NUM_TGT-1:0]     tgt_rd_valid_i,
  input  logic [8*NUM_TGT-1:0]   tgt_rdata_i,
  input  logic [NUM_TGT-1:0]     tgt_irq_i,
  input  logic [4*NUM_TGT-1:0]   tgt_irq_num_i
);

  localparam logic [15:0] WIN_MASK = win_mask(WIN_BITS);

  logic [2:0]         state;
  logic               is_wr;
  logic [NUM_TGT-1:0] sel;
  logic [NUM_TGT-1:0] hit;
  logic               hit_any;
  logic               wr_ack;
  logic               rd_ack;
  logic [7:0]         sel_rdata;
  logic               tmo_hit;
  logic [3:0]         irq_pick;
  logic               irq_found;

  lpc_addr_decode #(
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .WIN_BITS (WIN_BITS)
  ) u_decode (
    .addr_hi (lpc_addr_i[15:WIN_BITS]),
    .hit     (hit),
    .hit_any (hit_any)
  );

  assign wr_ack = |(tgt_wr_done_i & sel);
  assign rd_ack = |(tgt_rd_valid_i & sel);

  // Read data of the selected target; zero when nothing is selected.
  always_comb begin
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_TGT; k++) begin
      if (sel[k]) sel_rdata = sel_rdata | tgt_rdata_i[8*k +: 8];
    end
  end

`ifdef LPC_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC);
  logic [7:0] tmo_cnt;

  // Response timer: cleared while decoding, counts while waiting on a target.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      tmo_cnt <= '0;
    end else if (state == LPC_ARB_ST_DECODE) begin
      tmo_cnt <= '0;
    end else if ((state == LPC_ARB_ST_WR_WAIT) || (state == LPC_ARB_ST_RD_WAIT)) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // Transaction sequencer: decode, strobe the owning target, report back.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state         <= LPC_ARB_ST_IDLE;
      is_wr         <= 1'b0;
      sel           <= '0;
      tgt_wr_o      <= '0;
      tgt_rd_o      <= '0;
      tgt_addr_o    <= '0;
      tgt_wdata_o   <= '0;
      lpc_wr_done_o <= 1'b0;
      lpc_data_rd_o <= 1'b0;
      lpc_rdata_o   <= DFLT_RDATA;
    end else begin
      case (state)
        LPC_ARB_ST_IDLE: begin
          if (lpc_data_wr_i) begin
            is_wr <= 1'b1;
            state <= LPC_ARB_ST_DECODE;
          end else if (lpc_data_req_i) begin
            is_wr <= 1'b0;
            state <= LPC_ARB_ST_DECODE;
          end
        end
        LPC_ARB_ST_DECODE: begin
          if (hit_any) begin
            sel         <= hit;
            tgt_addr_o  <= lpc_addr_i & WIN_MASK;
            tgt_wdata_o <= lpc_wdata_i;
            if (is_wr) begin
              tgt_wr_o <= hit;
              state    <= LPC_ARB_ST_WR_WAIT;
            end else begin
              tgt_rd_o <= hit;
              state    <= LPC_ARB_ST_RD_WAIT;
            end
          end else if (is_wr) begin
            state <= LPC_ARB_ST_WR_DONE;
          end else begin
            lpc_rdata_o <= DFLT_RDATA;
            state       <= LPC_ARB_ST_RD_DONE;
          end
        end
        LPC_ARB_ST_WR_WAIT: begin
          if (!lpc_data_wr_i) begin
            tgt_wr_o <= '0;
            state    <= LPC_ARB_ST_IDLE;
          end else if (wr_ack || tmo_hit) begin
            tgt_wr_o <= '0;
            state    <= LPC_ARB_ST_WR_DONE;
          end
        end
        LPC_ARB_ST_RD_WAIT: begin
          if (!lpc_data_req_i) begin
            tgt_rd_o <= '0;
            state    <= LPC_ARB_ST_IDLE;
          end else if (rd_ack) begin
            tgt_rd_o    <= '0;
            lpc_rdata_o <= sel_rdata;
            state       <= LPC_ARB_ST_RD_DONE;
          end else if (tmo_hit) begin
            tgt_rd_o    <= '0;
            lpc_rdata_o <= DFLT_RDATA;
            state       <= LPC_ARB_ST_RD_DONE;
          end
        end
        LPC_ARB_ST_WR_DONE: begin
          if (!lpc_data_wr_i) begin
            lpc_wr_done_o <= 1'b0;
            state         <= LPC_ARB_ST_IDLE;
          end else begin
            lpc_wr_done_o <= 1'b1;
          end
        end
        LPC_ARB_ST_RD_DONE: begin
          if (!lpc_data_req_i) begin
            lpc_data_rd_o <= 1'b0;
            state         <= LPC_ARB_ST_IDLE;
          end else begin
            lpc_data_rd_o <= 1'b1;
          end
        end
        default: state <= LPC_ARB_ST_IDLE;
      endcase
    end
  end

  // Lowest-index asserting target supplies the IRQ number; otherwise hold.
  always_comb begin
    irq_pick  = irq_num_o;
    irq_found = 1'b0;
    for (int unsigned k = 0; k < NUM_TGT; k++) begin
      if (!irq_found && tgt_irq_i[k]) begin
        irq_pick  = tgt_irq_num_i[4*k +: 4];
        irq_found = 1'b1;
      end
    end
  end

  // Registered interrupt merge, independent of the transaction FSM.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      interrupt_o <= 1'b0;
      irq_num_o   <= '0;
    end else begin
      interrupt_o <= |tgt_irq_i;
      irq_num_o   <= irq_pick;
    end
  end

endmodule

// File: tb/tb_lpc_target_arbiter.sv
// Self-checking bench for lpc_target_arbiter with two targets
// (tgt0 window 0x0080, tgt1 window 0x0FE0, 16-byte windows).
module tb_lpc_target_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] lpc_addr;
  logic [7:0]  lpc_wdata;
  logic        lpc_wr;
  logic        lpc_wr_done;
  logic        lpc_req;
  logic        lpc_rd;
  logic [7:0]  lpc_rdata;
  logic [3:0]  irq_num;
  logic        interrupt;
  logic [15:0] tgt_addr;
  logic [7:0]  tgt_wdata;
  logic [1:0]  tgt_wr;
  logic [1:0]  tgt_wr_done;
  logic [1:0]  tgt_rd;
  logic [1:0]  tgt_rd_valid;
  logic [15:0] tgt_rdata;
  logic [1:0]  tgt_irq;
  logic [7:0]  tgt_irq_num;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  lpc_target_arbiter #(
    .NUM_TGT     (2),
    .TGT_BASE    ({16'h0FE0, 16'h0080}),
    .WIN_BITS    (4),
    .TIMEOUT_CYC (16),
    .DFLT_RDATA  (8'hFF)
  ) dut (
    .clk_i          (clk),
    .nrst_i         (nrst),
    .lpc_addr_i     (lpc_addr),
    .lpc_wdata_i    (lpc_wdata),
    .lpc_data_wr_i  (lpc_wr),
    .lpc_wr_done_o  (lpc_wr_done),
    .lpc_data_req_i (lpc_req),
    .lpc_data_rd_o  (lpc_rd),
    .lpc_rdata_o    (lpc_rdata),
    .irq_num_o      (irq_num),
    .interrupt_o    (interrupt),
    .tgt_addr_o     (tgt_addr),
    .tgt_wdata_o    (tgt_wdata),
    .tgt_wr_o       (tgt_wr),
    .tgt_wr_done_i  (tgt_wr_done),
    .tgt_rd_o       (tgt_rd),
    .tgt_rd_valid_i (tgt_rd_valid),
    .tgt_rdata_i    (tgt_rdata),
    .tgt_irq_i      (tgt_irq),
    .tgt_irq_num_i  (tgt_irq_num)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LPC read with an optional responding target; expected data goes through the scoreboard.
  task automatic lpc_read(input logic [15:0] addr, input int tgt, input logic [7:0] tdata,
                          input logic [7:0] exp, input bit decoy, output int lat);
    logic wrong;
    logic got;
    int   seen;
    logic [7:0] want;
    exp_q.push_back(exp);
    lpc_addr = addr;
    lpc_req  = 1'b1;
    lat = 0; wrong = 1'b0; got = 1'b0; seen = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      lat++;
      tgt_rd_valid = 2'b00;
      if (tgt >= 0) begin
        if ((tgt_rd & ~(2'b01 << tgt)) != 2'b00) wrong = 1'b1;
      end else if (tgt_rd != 2'b00) begin
        wrong = 1'b1;
      end
      if (lpc_rd) got = 1'b1;
      else if (tgt >= 0 && tgt_rd[tgt]) begin
        if (decoy && seen == 0) begin
          tgt_rdata[8*(1-tgt) +: 8] = 8'h11;
          tgt_rd_valid[1-tgt] = 1'b1;
        end else begin
          tgt_rdata[8*tgt +: 8] = tdata;
          tgt_rd_valid[tgt] = 1'b1;
        end
        seen++;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rd_timeout addr=%h got rd=%b exp rd=1", addr, lpc_rd);
      void'(exp_q.pop_front());
    end else begin
      want = exp_q.pop_front();
      checks++;
      if (lpc_rdata !== want) begin
        failures++;
        $display("FAIL rd_data addr=%h got=%h exp=%h", addr, lpc_rdata, want);
      end
      for (int h = 0; h < 2; h++) begin
        tick();
        checks++;
        if (lpc_rd !== 1'b1 || lpc_rdata !== want) begin
          failures++;
          $display("FAIL rd_hold got rd=%b data=%h exp rd=1 data=%h", lpc_rd, lpc_rdata, want);
        end
      end
    end
    checks++;
    if (wrong) begin
      failures++;
      $display("FAIL rd_strobe_target addr=%h got wrong-target strobe=1 exp=0", addr);
    end
    lpc_req = 1'b0;
    tick();
    checks++;
    if (lpc_rd !== 1'b0) begin
      failures++;
      $display("FAIL rd_release got=%b exp=0", lpc_rd);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    lpc_addr = '0; lpc_wdata = '0; lpc_wr = 1'b0; lpc_req = 1'b0;
    tgt_wr_done = '0; tgt_rd_valid = '0; tgt_rdata = '0; tgt_irq = '0; tgt_irq_num = '0;
    tick(); tick();
    checks++;
    if (lpc_wr_done !== 1'b0 || lpc_rd !== 1'b0 || lpc_rdata !== 8'hFF || tgt_wr !== 2'b00 ||
        tgt_rd !== 2'b00 || tgt_addr !== 16'h0 || tgt_wdata !== 8'h0 || interrupt !== 1'b0 || irq_num !== 4'h0) begin
      failures++;
      $display("FAIL reset got done=%b rd=%b rdata=%h wr=%b rds=%b addr=%h wd=%h int=%b num=%h exp rdata=ff others 0",
               lpc_wr_done, lpc_rd, lpc_rdata, tgt_wr, tgt_rd, tgt_addr, tgt_wdata, interrupt, irq_num);
    end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_write_tgt0();
    int strobe_cyc;
    lpc_addr = 16'h0083; lpc_wdata = 8'h5A; lpc_wr = 1'b1;
    tick(); tick();
    checks++;
    if (tgt_wr !== 2'b01 || tgt_addr !== 16'h0003 || tgt_wdata !== 8'h5A) begin
      failures++;
      $display("FAIL wr_strobe got wr=%b addr=%h data=%h exp wr=01 addr=0003 data=5a", tgt_wr, tgt_addr, tgt_wdata);
    end
    strobe_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (tgt_wr === 2'b01) strobe_cyc++;
      if (i == 2) tgt_wr_done = 2'b01;
      tick();
    end
    tgt_wr_done = 2'b00;
    checks++;
    if (strobe_cyc != 3 || tgt_wr !== 2'b00) begin
      failures++;
      $display("FAIL wr_strobe_len got cycles=%0d wr=%b exp cycles=3 wr=00", strobe_cyc, tgt_wr);
    end
    tick();
    checks++;
    if (lpc_wr_done !== 1'b1) begin
      failures++;
      $display("FAIL wr_done_rise got=%b exp=1", lpc_wr_done);
    end
    tick(); tick();
    checks++;
    if (lpc_wr_done !== 1'b1) begin
      failures++;
      $display("FAIL wr_done_hold got=%b exp=1", lpc_wr_done);
    end
    lpc_wr = 1'b0;
    tick();
    checks++;
    if (lpc_wr_done !== 1'b0) begin
      failures++;
      $display("FAIL wr_done_fall got=%b exp=0", lpc_wr_done);
    end
  endtask

  task automatic test_read_tgt1();
    int lat;
    // tgt0 raises a stray valid first; it must not complete the transaction.
    lpc_read(16'h0FE2, 1, 8'hC3, 8'hC3, 1'b1, lat);
    checks++;
    if (tgt_addr !== 16'h0002) begin
      failures++;
      $display("FAIL rd_tgt_addr got=%h exp=0002", tgt_addr);
    end
  endtask

  task automatic test_unclaimed();
    int lat;
    logic strobed;
    lpc_read(16'h0300, -1, 8'h00, 8'hFF, 1'b0, lat);
    // request seen at the first edge, data reported two edges later
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL miss_rd_latency got=%0d exp=3", lat);
    end
    lpc_addr = 16'h0300; lpc_wdata = 8'h99; lpc_wr = 1'b1;
    strobed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tgt_wr != 2'b00 || tgt_rd != 2'b00) strobed = 1'b1;
    end
    checks++;
    if (lpc_wr_done !== 1'b1 || strobed) begin
      failures++;
      $display("FAIL miss_wr got done=%b strobed=%b exp done=1 strobed=0", lpc_wr_done, strobed);
    end
    lpc_wr = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int lat;
    logic rd_seen;
    lpc_addr = 16'h0080; lpc_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (tgt_rd !== 2'b01) begin
      failures++;
      $display("FAIL abort_pre_strobe got=%b exp=01", tgt_rd);
    end
    lpc_req = 1'b0;
    tick();
    checks++;
    if (tgt_rd !== 2'b00) begin
      failures++;
      $display("FAIL abort_strobe_drop got=%b exp=00", tgt_rd);
    end
    tgt_rdata[7:0] = 8'h42; tgt_rd_valid = 2'b01;
    tick();
    tgt_rd_valid = 2'b00;
    rd_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lpc_rd !== 1'b0) rd_seen = 1'b1;
      tick();
    end
    checks++;
    if (rd_seen) begin
      failures++;
      $display("FAIL abort_no_rd got rd=1 exp=0");
    end
    lpc_read(16'h0081, 0, 8'h77, 8'h77, 1'b0, lat);
  endtask

  task automatic test_irq();
    tgt_irq_num = {4'd11, 4'd5};
    tgt_irq = 2'b11;
    checks++;
    if (interrupt !== 1'b0) begin
      failures++;
      $display("FAIL irq_latency got=%b exp=0", interrupt);
    end
    tick();
    checks++;
    if (interrupt !== 1'b1 || irq_num !== 4'd5) begin
      failures++;
      $display("FAIL irq_both got int=%b num=%0d exp int=1 num=5", interrupt, irq_num);
    end
    tgt_irq = 2'b10;
    tick();
    checks++;
    if (interrupt !== 1'b1 || irq_num !== 4'd11) begin
      failures++;
      $display("FAIL irq_tgt1 got int=%b num=%0d exp int=1 num=11", interrupt, irq_num);
    end
    tgt_irq = 2'b00;
    tick();
    checks++;
    if (interrupt !== 1'b0 || irq_num !== 4'd11) begin
      failures++;
      $display("FAIL irq_clear got int=%b num=%0d exp int=0 num=11", interrupt, irq_num);
    end
  endtask

  task automatic test_silent_target();
    int lat;
    logic got;
    logic [7:0] want;
    lpc_addr = 16'h0085; lpc_req = 1'b1;
`ifdef LPC_ARB_TIMEOUT_EN
    exp_q.push_back(8'hFF);
    got = 1'b0; lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      lat++;
      if (lpc_rd) got = 1'b1;
    end
    want = exp_q.pop_front();
    checks++;
    if (!got || lpc_rdata !== want || lat < 18 || tgt_rd !== 2'b00) begin
      failures++;
      $display("FAIL timeout_rd got rd=%b data=%h lat=%0d strobe=%b exp rd=1 data=%h lat>=18 strobe=00",
               lpc_rd, lpc_rdata, lat, tgt_rd, want);
    end
    lpc_req = 1'b0;
    tick();
`else
    got = 1'b0;
    want = 8'h00;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (lpc_rd) got = 1'b1;
    end
    checks++;
    if (got || tgt_rd !== 2'b01) begin
      failures++;
      $display("FAIL silent_wait got rd_seen=%b strobe=%b exp rd_seen=0 strobe=01 (data %h lat %0d)",
               got, tgt_rd, want, lat);
    end
    lpc_req = 1'b0;
    tick();
    checks++;
    if (tgt_rd !== 2'b00) begin
      failures++;
      $display("FAIL silent_abort got=%b exp=00", tgt_rd);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    lpc_read(16'h008F, 0, 8'hA5, 8'hA5, 1'b0, lat);
    lpc_read(16'h0FEF, 1, 8'h3C, 8'h3C, 1'b0, lat);
    checks++;
    if (tgt_addr !== 16'h000F) begin
      failures++;
      $display("FAIL b2b_addr got=%h exp=000f", tgt_addr);
    end
  endtask

  initial begin
    test_reset();
    test_write_tgt0();
    test_read_tgt1();
    test_unclaimed();
    test_abort();
    test_irq();
    test_silent_target();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
